pic_rw_sequencer: RTL and testbench

Upstream front end of the 8259-style interrupt controller. It takes CPU bus writes and reads (CS_N, WR_N, RD_N, A0, data) and runs the ICW1→ICW2→(ICW3)→(ICW4) initialization sequence. It then decodes OCW1/OCW2/OCW3 writes and presents the held ICW1–ICW4, OCW1–OCW3 bytes that Control_logic consumes. It also returns IRR, ISR or IMR on bus reads.

---
 rtl/pic_pkg.sv | 31 +++
 rtl/pic_wr_strobe.sv | 23 ++
 rtl/pic_rw_sequencer.sv | 163 ++++++++++++++++
 tb/tb_pic_rw_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259-style bus front end.
// PIC_CASCADE_EN selects whether the ICW3 (cascade) step exists.
package pic_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitIcw2,
`ifdef PIC_CASCADE_EN
    StWaitIcw3,
`endif
    StWaitIcw4,
    StReady
  } pic_state_e;

  localparam logic [7:0] OCW3_RST = 8'h0A;

  localparam int unsigned IC4     = 0;
  localparam int unsigned SNGL    = 1;
  localparam int unsigned ICW1_ID = 4;
  localparam int unsigned OCW_SEL = 3;
  localparam int unsigned RR      = 1;
  localparam int unsigned RIS     = 0;

  // Without cascade support the SNGL bit is held at 1 from reset onward.
`ifdef PIC_CASCADE_EN
  localparam logic [7:0] ICW1_RST = 8'h00;
`else
  localparam logic [7:0] ICW1_RST = 8'h02;
`endif

endpackage

// File: rtl/pic_wr_strobe.sv
// Registers WR_N and emits a one-cycle pulse on the falling edge of a
// chip-selected write, so a long low pulse is accepted exactly once.
module pic_wr_strobe (
  input  logic clk_i,
  input  logic rst_i,
  input  logic cs_n_i,
  input  logic wr_n_i,
  output logic wr_stb_o
);

  logic wr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= 1'b1;
    end else begin
      wr_q <= wr_n_i;
    end
  end

  assign wr_stb_o = !cs_n_i && wr_q && !wr_n_i;

endmodule

// File: rtl/pic_rw_sequencer.sv
// Bus front end of the 8259-style PIC: ICW init sequence, OCW decode, read mux.
// PIC_CASCADE_EN enables the ICW3 step and the ICW3 register.
module pic_rw_sequencer
  import pic_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       CS_N,
  input  logic       WR_N,
  input  logic       RD_N,
  input  logic       A0,
  input  logic [7:0] D_IN,
  input  logic [7:0] IRR,
  input  logic [7:0] ISR,
  output logic [7:0] ICW1,
  output logic [7:0] ICW2,
  output logic [7:0] ICW3,
  output logic [7:0] ICW4,
  output logic [7:0] OCW1,
  output logic [7:0] OCW2,
  output logic [7:0] OCW3,
  output logic       INIT_DONE,
  output logic       EOI_STB,
  output logic [7:0] D_OUT,
  output logic       D_OE
);

  pic_state_e state_q, state_d;
  logic [7:0] icw1_q, icw1_d, icw2_q, icw2_d, icw4_q, icw4_d;
  logic [7:0] ocw1_q, ocw1_d, ocw2_q, ocw2_d, ocw3_q, ocw3_d;
  logic       eoi_q, eoi_d;
  logic       wr_stb;
`ifdef PIC_CASCADE_EN
  logic [7:0] icw3_q, icw3_d;
`endif

  pic_wr_strobe u_wr_strobe (
    .clk_i    (CLK),
    .rst_i    (RST),
    .cs_n_i   (CS_N),
    .wr_n_i   (WR_N),
    .wr_stb_o (wr_stb)
  );

  always_comb begin
    state_d = state_q;
    icw1_d  = icw1_q;
    icw2_d  = icw2_q;
    icw4_d  = icw4_q;
    ocw1_d  = ocw1_q;
    ocw2_d  = ocw2_q;
    ocw3_d  = ocw3_q;
    eoi_d   = 1'b0;
`ifdef PIC_CASCADE_EN
    icw3_d  = icw3_q;
`endif
    if (wr_stb) begin
      if (!A0 && D_IN[ICW1_ID]) begin
        // ICW1 restarts initialization from any state.
`ifdef PIC_CASCADE_EN
        icw1_d = D_IN;
        icw3_d = 8'h00;
`else
        icw1_d = {D_IN[7:2], 1'b1, D_IN[0]};
`endif
        icw2_d  = 8'h00;
        icw4_d  = 8'h00;
        ocw1_d  = 8'h00;
        ocw2_d  = 8'h00;
        ocw3_d  = OCW3_RST;
        state_d = StWaitIcw2;
      end else begin
        case (state_q)
          StWaitIcw2: if (A0) begin
            icw2_d = D_IN;
`ifdef PIC_CASCADE_EN
            if (!icw1_q[SNGL])     state_d = StWaitIcw3;
            else if (icw1_q[IC4])  state_d = StWaitIcw4;
            else                   state_d = StReady;
`else
            state_d = icw1_q[IC4] ? StWaitIcw4 : StReady;
`endif
          end
`ifdef PIC_CASCADE_EN
          StWaitIcw3: if (A0) begin
            icw3_d  = D_IN;
            state_d = icw1_q[IC4] ? StWaitIcw4 : StReady;
          end
`endif
          StWaitIcw4: if (A0) begin
            icw4_d  = D_IN;
            state_d = StReady;
          end
          StReady: begin
            if (A0) begin
              ocw1_d = D_IN;
            end else if (D_IN[OCW_SEL+:2] == 2'b00) begin
              ocw2_d = D_IN;
              eoi_d  = 1'b1;
            end else if (D_IN[OCW_SEL+:2] == 2'b01) begin
              // Read-register select only changes when RR is set.
              ocw3_d = D_IN[RR] ? D_IN : {D_IN[7:2], ocw3_q[1:0]};
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      icw1_q  <= ICW1_RST;
      icw2_q  <= 8'h00;
      icw4_q  <= 8'h00;
      ocw1_q  <= 8'h00;
      ocw2_q  <= 8'h00;
      ocw3_q  <= OCW3_RST;
      eoi_q   <= 1'b0;
`ifdef PIC_CASCADE_EN
      icw3_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      icw1_q  <= icw1_d;
      icw2_q  <= icw2_d;
      icw4_q  <= icw4_d;
      ocw1_q  <= ocw1_d;
      ocw2_q  <= ocw2_d;
      ocw3_q  <= ocw3_d;
      eoi_q   <= eoi_d;
`ifdef PIC_CASCADE_EN
      icw3_q  <= icw3_d;
`endif
    end
  end

`ifdef PIC_CASCADE_EN
  assign ICW3 = icw3_q;
`else
  assign ICW3 = 8'h00;
`endif
  assign ICW1      = icw1_q;
  assign ICW2      = icw2_q;
  assign ICW4      = icw4_q;
  assign OCW1      = ocw1_q;
  assign OCW2      = ocw2_q;
  assign OCW3      = ocw3_q;
  assign INIT_DONE = (state_q == StReady);
  assign EOI_STB   = eoi_q;

  always_comb begin
    D_OE  = !CS_N && !RD_N && WR_N;
    D_OUT = 8'h00;
    if (D_OE) begin
      if (A0)               D_OUT = ocw1_q;
      else if (ocw3_q[RIS]) D_OUT = ISR;
      else                  D_OUT = IRR;
    end
  end

endmodule

// File: tb/tb_pic_rw_sequencer.sv
// Directed bench for pic_rw_sequencer; expectations follow PIC_CASCADE_EN.
module tb_pic_rw_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       CS_N = 1'b1;
  logic       WR_N = 1'b1;
  logic       RD_N = 1'b1;
  logic       A0 = 1'b0;
  logic [7:0] D_IN = 8'h00;
  logic [7:0] IRR = 8'h81;
  logic [7:0] ISR = 8'h40;
  logic [7:0] ICW1, ICW2, ICW3, ICW4, OCW1, OCW2, OCW3, D_OUT;
  logic       INIT_DONE, EOI_STB, D_OE;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int unsigned eoi_cnt;

`ifdef PIC_CASCADE_EN
  localparam logic [7:0] ICW1_RST_EXP = 8'h00;
`else
  localparam logic [7:0] ICW1_RST_EXP = 8'h02;
`endif

  always #5 CLK = ~CLK;

  pic_rw_sequencer dut (
    .CLK       (CLK),
    .RST       (RST),
    .CS_N      (CS_N),
    .WR_N      (WR_N),
    .RD_N      (RD_N),
    .A0        (A0),
    .D_IN      (D_IN),
    .IRR       (IRR),
    .ISR       (ISR),
    .ICW1      (ICW1),
    .ICW2      (ICW2),
    .ICW3      (ICW3),
    .ICW4      (ICW4),
    .OCW1      (OCW1),
    .OCW2      (OCW2),
    .OCW3      (OCW3),
    .INIT_DONE (INIT_DONE),
    .EOI_STB   (EOI_STB),
    .D_OUT     (D_OUT),
    .D_OE      (D_OE)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Two-cycle write pulse; returns at the negedge after the accepting edge.
  task automatic do_write(input logic a0, input logic [7:0] d);
    @(negedge CLK);
    CS_N = 1'b0; A0 = a0; D_IN = d; WR_N = 1'b0;
    @(negedge CLK);
    WR_N = 1'b1; CS_N = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_icw1"}, ICW1, ICW1_RST_EXP);
    check({tag, "_icw2"}, ICW2, 8'h00);
    check({tag, "_icw3"}, ICW3, 8'h00);
    check({tag, "_icw4"}, ICW4, 8'h00);
    check({tag, "_ocw1"}, OCW1, 8'h00);
    check({tag, "_ocw2"}, OCW2, 8'h00);
    check({tag, "_ocw3"}, OCW3, 8'h0A);
    check({tag, "_init"}, {7'd0, INIT_DONE}, 8'h00);
    check({tag, "_eoi"},  {7'd0, EOI_STB}, 8'h00);
  endtask

  initial begin
    do_reset();
    check_reset_state("rst");
    check("rst_doe", {7'd0, D_OE}, 8'h00);
    check("rst_dout", D_OUT, 8'h00);

    // Single mode, no ICW4
    do_write(1'b0, 8'h1A);
    check("sngl_init_mid", {7'd0, INIT_DONE}, 8'h00);
    do_write(1'b1, 8'hA8);
    check("sngl_icw1", ICW1, 8'h1A);
    check("sngl_icw2", ICW2, 8'hA8);
    check("sngl_icw3", ICW3, 8'h00);
    check("sngl_icw4", ICW4, 8'h00);
    check("sngl_init", {7'd0, INIT_DONE}, 8'h01);

    // READY: OCW writes and reads
    do_write(1'b1, 8'h07);
    check("ocw1", OCW1, 8'h07);
    @(negedge CLK); CS_N = 1'b0; RD_N = 1'b0; A0 = 1'b1; #1;
    check("rd_imr", D_OUT, 8'h07);
    check("rd_imr_oe", {7'd0, D_OE}, 8'h01);
    CS_N = 1'b1; RD_N = 1'b1;
    do_write(1'b0, 8'h20);
    check("ocw2", OCW2, 8'h20);
    check("eoi_hi", {7'd0, EOI_STB}, 8'h01);
    @(negedge CLK);
    check("eoi_lo", {7'd0, EOI_STB}, 8'h00);
    @(negedge CLK); CS_N = 1'b0; RD_N = 1'b0; A0 = 1'b0; #1;
    check("rd_irr", D_OUT, 8'h81);
    CS_N = 1'b1; RD_N = 1'b1;
    do_write(1'b0, 8'h0B);
    check("ocw3_rr", OCW3, 8'h0B);
    @(negedge CLK); CS_N = 1'b0; RD_N = 1'b0; A0 = 1'b0; #1;
    check("rd_isr", D_OUT, 8'h40);
    check("rd_isr_oe", {7'd0, D_OE}, 8'h01);
    CS_N = 1'b1; RD_N = 1'b1;
    do_write(1'b0, 8'h68);
    check("ocw3_keep", OCW3, 8'h6B);
    // WR and RD low together: write lands, read is suppressed
    @(negedge CLK);
    CS_N = 1'b0; A0 = 1'b1; D_IN = 8'h3C; RD_N = 1'b0; WR_N = 1'b0; #1;
    check("wrrd_oe", {7'd0, D_OE}, 8'h00);
    check("wrrd_dout", D_OUT, 8'h00);
    @(negedge CLK);
    WR_N = 1'b1; RD_N = 1'b1; CS_N = 1'b1;
    check("wrrd_ocw1", OCW1, 8'h3C);

    // Cascade sequence 0x11, 0x08, 0x04, 0x02
    do_write(1'b0, 8'h11);
`ifdef PIC_CASCADE_EN
    check("casc_icw1", ICW1, 8'h11);
`else
    check("casc_icw1", ICW1, 8'h13);
`endif
    check("casc_ocw3", OCW3, 8'h0A);
    check("casc_ocw1", OCW1, 8'h00);
    do_write(1'b1, 8'h08);
    check("casc_icw2", ICW2, 8'h08);
    check("casc_init2", {7'd0, INIT_DONE}, 8'h00);
    do_write(1'b1, 8'h04);
`ifdef PIC_CASCADE_EN
    check("casc_icw3", ICW3, 8'h04);
    check("casc_init3", {7'd0, INIT_DONE}, 8'h00);
`else
    check("casc_icw4a", ICW4, 8'h04);
    check("casc_init3", {7'd0, INIT_DONE}, 8'h01);
`endif
    do_write(1'b1, 8'h02);
`ifdef PIC_CASCADE_EN
    check("casc_icw4", ICW4, 8'h02);
    check("casc_init4", {7'd0, INIT_DONE}, 8'h01);
`else
    check("casc_ocw1b", OCW1, 8'h02);
    check("casc_icw4b", ICW4, 8'h04);
`endif

    // Re-init mid-sequence
    do_write(1'b0, 8'h1B);
    do_write(1'b1, 8'h20);
    check("reinit_icw2a", ICW2, 8'h20);
    do_write(1'b0, 8'h1A);
    check("reinit_icw1", ICW1, 8'h1A);
    check("reinit_icw2", ICW2, 8'h00);
    check("reinit_ocw1", OCW1, 8'h00);
    check("reinit_init", {7'd0, INIT_DONE}, 8'h00);
    do_write(1'b0, 8'h08);
    check("ign_icw2", ICW2, 8'h00);
    do_write(1'b1, 8'h55);
    check("reinit_icw2b", ICW2, 8'h55);
    check("reinit_done", {7'd0, INIT_DONE}, 8'h01);

    // Long write pulse: one OCW2 accept, one EOI pulse
    eoi_cnt = 0;
    @(negedge CLK);
    CS_N = 1'b0; A0 = 1'b0; D_IN = 8'h60; WR_N = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (EOI_STB) eoi_cnt++;
    end
    WR_N = 1'b1; CS_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (EOI_STB) eoi_cnt++;
    end
    check("hold_eoi_cnt", 8'(eoi_cnt), 8'h01);
    check("hold_ocw2", OCW2, 8'h60);

    // Reset during WAIT_ICW4, with a write in the same cycle
    do_write(1'b0, 8'h1B);
    do_write(1'b1, 8'h30);
    check("w4_init", {7'd0, INIT_DONE}, 8'h00);
    @(negedge CLK);
    RST = 1'b1; CS_N = 1'b0; A0 = 1'b0; D_IN = 8'h1A; WR_N = 1'b0;
    @(negedge CLK);
    RST = 1'b0; WR_N = 1'b1; CS_N = 1'b1;
    check_reset_state("rst2");
    do_write(1'b1, 8'h44);
    check("idle_ign_icw2", ICW2, 8'h00);
    check("idle_ign_init", {7'd0, INIT_DONE}, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
